exp5_unidade_controle_rodadas: RTL and testbench

Moore control unit for the memory-sequence game, successor to the single-pass controller. It runs rounds of growing length: round r checks addresses 0..r against the player's plays, then extends the limit. It waits for a play strobe under a programmable timeout. Terminal states hold their result until a new start. Drives the address counter (E), limit counter (L) and play register (R) in the datapath.

---
 rtl/exp5_pkg.sv | 70 +++++++
 rtl/exp5_unidade_controle_rodadas_contador_timeout.sv | 36 +++
 rtl/exp5_unidade_controle_rodadas.sv | 126 ++++++++++++
 tb/tb_exp5_unidade_controle_rodadas.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/exp5_pkg.sv
// Shared state codes and Moore output decode for the exp5 round controller.
// Build option EXP5_TIMEOUT_EN enables the timeout state (0xC); otherwise 0xC decodes as illegal.
package exp5_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL        = 4'h0,
        ST_PREPARACAO     = 4'h1,
        ST_INICIA_RODADA  = 4'h2,
        ST_ESPERA         = 4'h3,
        ST_REGISTRA       = 4'h4,
        ST_COMPARACAO     = 4'h5,
        ST_PROXIMO        = 4'h6,
        ST_PROXIMA_RODADA = 4'h7,
        ST_FIM_ACERTO     = 4'hA,
        ST_FIM_TIMEOUT    = 4'hC,
        ST_FIM_ERRO       = 4'hE
    } estado_t;

    localparam logic [3:0] DB_ILEGAL = 4'hF;

    typedef struct packed {
        logic       zera_e;
        logic       conta_e;
        logic       zera_l;
        logic       conta_l;
        logic       zera_r;
        logic       registra_r;
        logic       pronto;
        logic       acertou;
        logic       errou;
        logic       timeout;
        logic [3:0] db_estado;
    } ctrl_out_t;

    function automatic ctrl_out_t decodifica_saidas(input logic [3:0] estado);
        ctrl_out_t o;
        o           = '0;
        o.db_estado = estado;
        case (estado)
            ST_INICIAL, ST_PREPARACAO: begin
                o.zera_e = 1'b1;
                o.zera_l = 1'b1;
                o.zera_r = 1'b1;
            end
            ST_INICIA_RODADA:  o.zera_e     = 1'b1;
            ST_ESPERA:         o.zera_e     = 1'b0;
            ST_REGISTRA:       o.registra_r = 1'b1;
            ST_COMPARACAO:     o.zera_e     = 1'b0;
            ST_PROXIMO:        o.conta_e    = 1'b1;
            ST_PROXIMA_RODADA: o.conta_l    = 1'b1;
            ST_FIM_ACERTO: begin
                o.pronto  = 1'b1;
                o.acertou = 1'b1;
            end
            ST_FIM_ERRO: begin
                o.pronto = 1'b1;
                o.errou  = 1'b1;
            end
`ifdef EXP5_TIMEOUT_EN
            ST_FIM_TIMEOUT: begin
                o.pronto  = 1'b1;
                o.timeout = 1'b1;
            end
`endif
            default:           o.db_estado  = DB_ILEGAL;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/exp5_unidade_controle_rodadas_contador_timeout.sv
// Wait-for-play timeout counter: fim asserts on the last allowed cycle in espera.
// Only instantiated when EXP5_TIMEOUT_EN is defined.
module contador_timeout #(
    parameter int TIMEOUT_CYCLES = 3000,
    parameter int TMR_W          = 12
) (
    input  logic clock,
    input  logic reset_n,
    input  logic conta,
    input  logic zera,
    output logic fim
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (zera) begin
            cnt_d = '0;
        end else if (conta) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim = (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/exp5_unidade_controle_rodadas.sv
// Moore round controller for the memory-sequence game (growing rounds, play timeout).
// Build option EXP5_TIMEOUT_EN adds the espera timeout; without it espera waits indefinitely.
module exp5_unidade_controle_rodadas #(
    parameter int TIMEOUT_CYCLES = 3000,
    parameter int TMR_W          = 12
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimE,
    input  logic       fimL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    import exp5_pkg::*;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    if ((2 ** TMR_W) <= TIMEOUT_CYCLES) begin : g_bad_width
        $error("TMR_W too narrow for TIMEOUT_CYCLES");
    end

    estado_t   estado_q;
    estado_t   estado_d;
    ctrl_out_t saidas_q;
    ctrl_out_t saidas_d;

`ifdef EXP5_TIMEOUT_EN
    logic fim_tmr;
    logic conta_tmr;
    logic zera_tmr;

    // Timer reads 0 on the first espera cycle and is cleared on the edge that leaves espera.
    assign conta_tmr = (estado_q == ST_ESPERA) && (estado_d == ST_ESPERA);
    assign zera_tmr  = !conta_tmr;

    contador_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TMR_W         (TMR_W)
    ) u_contador_timeout (
        .clock  (clock),
        .reset_n(reset_n),
        .conta  (conta_tmr),
        .zera   (zera_tmr),
        .fim    (fim_tmr)
    );
`endif

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_INICIAL:        if (iniciar) estado_d = ST_PREPARACAO;
            ST_PREPARACAO:     estado_d = ST_INICIA_RODADA;
            ST_INICIA_RODADA:  estado_d = ST_ESPERA;
            ST_ESPERA: begin
                if (jogada) begin
                    estado_d = ST_REGISTRA;
                end
`ifdef EXP5_TIMEOUT_EN
                else if (fim_tmr) begin
                    estado_d = ST_FIM_TIMEOUT;
                end
`endif
            end
            ST_REGISTRA:       estado_d = ST_COMPARACAO;
            ST_COMPARACAO: begin
                if (!igual) begin
                    estado_d = ST_FIM_ERRO;
                end else if (!fimE) begin
                    estado_d = ST_PROXIMO;
                end else if (fimL) begin
                    estado_d = ST_FIM_ACERTO;
                end else begin
                    estado_d = ST_PROXIMA_RODADA;
                end
            end
            ST_PROXIMO:        estado_d = ST_ESPERA;
            ST_PROXIMA_RODADA: estado_d = ST_INICIA_RODADA;
`ifdef EXP5_TIMEOUT_EN
            ST_FIM_ACERTO, ST_FIM_ERRO, ST_FIM_TIMEOUT:
`else
            ST_FIM_ACERTO, ST_FIM_ERRO:
`endif
                if (iniciar) estado_d = ST_PREPARACAO;
            default:           estado_d = ST_INICIAL;
        endcase
        saidas_d = decodifica_saidas(estado_d);
    end

    // Outputs are registered alongside the state so they are a pure function of it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= ST_INICIAL;
            saidas_q <= decodifica_saidas(ST_INICIAL);
        end else begin
            estado_q <= estado_d;
            saidas_q <= saidas_d;
        end
    end

    assign zeraE     = saidas_q.zera_e;
    assign contaE    = saidas_q.conta_e;
    assign zeraL     = saidas_q.zera_l;
    assign contaL    = saidas_q.conta_l;
    assign zeraR     = saidas_q.zera_r;
    assign registraR = saidas_q.registra_r;
    assign pronto    = saidas_q.pronto;
    assign acertou   = saidas_q.acertou;
    assign errou     = saidas_q.errou;
    assign timeout   = saidas_q.timeout;
    assign db_estado = saidas_q.db_estado;

endmodule

// File: tb/tb_exp5_unidade_controle_rodadas.sv
// Directed bench for the exp5 round controller, TIMEOUT_CYCLES=8.
// Timeout scenarios run when EXP5_TIMEOUT_EN is defined; otherwise the indefinite-wait path is checked.
module tb_exp5_unidade_controle_rodadas;

    import exp5_pkg::*;

    // Flag order: zeraE contaE zeraL contaL zeraR registraR pronto acertou errou timeout
    localparam logic [9:0] F_ZERA3   = 10'b1010100000;
    localparam logic [9:0] F_ZERA_E  = 10'b1000000000;
    localparam logic [9:0] F_NONE    = 10'b0000000000;
    localparam logic [9:0] F_REG     = 10'b0000010000;
    localparam logic [9:0] F_CONTA_E = 10'b0100000000;
    localparam logic [9:0] F_CONTA_L = 10'b0001000000;
    localparam logic [9:0] F_ACERTO  = 10'b0000001100;
    localparam logic [9:0] F_ERRO    = 10'b0000001010;
    localparam logic [9:0] F_TIMEOUT = 10'b0000001001;

    logic       clock;
    logic       reset_n;
    logic       iniciar, jogada, igual, fimE, fimL;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    exp5_unidade_controle_rodadas #(
        .TIMEOUT_CYCLES(8),
        .TMR_W         (4)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .iniciar  (iniciar),
        .jogada   (jogada),
        .igual    (igual),
        .fimE     (fimE),
        .fimL     (fimL),
        .zeraE    (zeraE),
        .contaE   (contaE),
        .zeraL    (zeraL),
        .contaL   (contaL),
        .zeraR    (zeraR),
        .registraR(registraR),
        .pronto   (pronto),
        .acertou  (acertou),
        .errou    (errou),
        .timeout  (timeout),
        .db_estado(db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs are {iniciar, jogada, igual, fimE, fimL}, held across one rising edge.
    task automatic applyStimulus(input logic [4:0] in);
        {iniciar, jogada, igual, fimE, fimL} = in;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_db, input logic [9:0] exp_flags);
        logic [13:0] observed;
        logic [13:0] expected;
        observed = {db_estado, zeraE, contaE, zeraL, contaL, zeraR, registraR,
                    pronto, acertou, errou, timeout};
        expected = {exp_db, exp_flags};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        {iniciar, jogada, igual, fimE, fimL} = 5'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        checkOutput("reset_async", ST_INICIAL, F_ZERA3);
        #9 reset_n = 1'b1;

        applyStimulus(5'b00000); checkOutput("inicial_idle", ST_INICIAL, F_ZERA3);
        applyStimulus(5'b01000); checkOutput("stray_jogada_inicial", ST_INICIAL, F_ZERA3);
        applyStimulus(5'b10000); checkOutput("r0_preparacao", ST_PREPARACAO, F_ZERA3);
        applyStimulus(5'b00110); checkOutput("r0_inicia_rodada", ST_INICIA_RODADA, F_ZERA_E);
        applyStimulus(5'b00110); checkOutput("r0_espera", ST_ESPERA, F_NONE);
        applyStimulus(5'b01110); checkOutput("r0_registra", ST_REGISTRA, F_REG);
        applyStimulus(5'b00110); checkOutput("r0_comparacao", ST_COMPARACAO, F_NONE);
        applyStimulus(5'b00110); checkOutput("r0_proxima_rodada", ST_PROXIMA_RODADA, F_CONTA_L);
        applyStimulus(5'b00110); checkOutput("r1_inicia_rodada", ST_INICIA_RODADA, F_ZERA_E);
        applyStimulus(5'b00100); checkOutput("r1_espera", ST_ESPERA, F_NONE);
        applyStimulus(5'b01100); checkOutput("r1_registra_a", ST_REGISTRA, F_REG);
        applyStimulus(5'b00100); checkOutput("r1_comparacao_a", ST_COMPARACAO, F_NONE);
        applyStimulus(5'b00100); checkOutput("r1_proximo", ST_PROXIMO, F_CONTA_E);
        applyStimulus(5'b00111); checkOutput("r1_espera_b", ST_ESPERA, F_NONE);
        applyStimulus(5'b01111); checkOutput("r1_registra_b", ST_REGISTRA, F_REG);
        applyStimulus(5'b00111); checkOutput("r1_comparacao_b", ST_COMPARACAO, F_NONE);
        applyStimulus(5'b00111); checkOutput("win", ST_FIM_ACERTO, F_ACERTO);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(5'b01111); checkOutput("win_hold", ST_FIM_ACERTO, F_ACERTO);
        end

        applyStimulus(5'b10000); checkOutput("err_preparacao", ST_PREPARACAO, F_ZERA3);
        applyStimulus(5'b00000); checkOutput("err_inicia_rodada", ST_INICIA_RODADA, F_ZERA_E);
        applyStimulus(5'b00000); checkOutput("err_espera", ST_ESPERA, F_NONE);
        applyStimulus(5'b01000); checkOutput("err_registra", ST_REGISTRA, F_REG);
        applyStimulus(5'b00000); checkOutput("err_comparacao", ST_COMPARACAO, F_NONE);
        applyStimulus(5'b00000); checkOutput("err_fim", ST_FIM_ERRO, F_ERRO);
        applyStimulus(5'b01000); checkOutput("err_hold_a", ST_FIM_ERRO, F_ERRO);
        applyStimulus(5'b00000); checkOutput("err_hold_b", ST_FIM_ERRO, F_ERRO);
        applyStimulus(5'b10000); checkOutput("err_restart", ST_PREPARACAO, F_ZERA3);

        applyStimulus(5'b00000); checkOutput("to_inicia_rodada", ST_INICIA_RODADA, F_ZERA_E);
        applyStimulus(5'b00000); checkOutput("to_espera_c1", ST_ESPERA, F_NONE);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(5'b00000); checkOutput("to_espera_dwell", ST_ESPERA, F_NONE);
        end
`ifdef EXP5_TIMEOUT_EN
        applyStimulus(5'b00000); checkOutput("to_fim", ST_FIM_TIMEOUT, F_TIMEOUT);
        applyStimulus(5'b01000); checkOutput("to_hold", ST_FIM_TIMEOUT, F_TIMEOUT);
        applyStimulus(5'b10000); checkOutput("to_restart", ST_PREPARACAO, F_ZERA3);
`else
        for (int i = 0; i < 100; i++) begin
            applyStimulus(5'b00000); checkOutput("no_to_idle", ST_ESPERA, F_NONE);
        end
        applyStimulus(5'b10000); checkOutput("no_to_iniciar_ignored", ST_ESPERA, F_NONE);
        applyStimulus(5'b01000); checkOutput("no_to_registra", ST_REGISTRA, F_REG);
        applyStimulus(5'b00000); checkOutput("no_to_comparacao", ST_COMPARACAO, F_NONE);
        applyStimulus(5'b00000); checkOutput("no_to_erro", ST_FIM_ERRO, F_ERRO);
        applyStimulus(5'b10000); checkOutput("no_to_restart", ST_PREPARACAO, F_ZERA3);
`endif

        applyStimulus(5'b00000); checkOutput("race_inicia_rodada", ST_INICIA_RODADA, F_ZERA_E);
        applyStimulus(5'b00000); checkOutput("race_espera_c1", ST_ESPERA, F_NONE);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(5'b00000); checkOutput("race_espera_dwell", ST_ESPERA, F_NONE);
        end
        applyStimulus(5'b01111); checkOutput("race_jogada_wins", ST_REGISTRA, F_REG);
        applyStimulus(5'b00111); checkOutput("race_comparacao", ST_COMPARACAO, F_NONE);
        applyStimulus(5'b00111); checkOutput("race_win", ST_FIM_ACERTO, F_ACERTO);

        applyStimulus(5'b10000); checkOutput("rst_preparacao", ST_PREPARACAO, F_ZERA3);
        applyStimulus(5'b00000); checkOutput("rst_inicia_rodada", ST_INICIA_RODADA, F_ZERA_E);
        applyStimulus(5'b00000); checkOutput("rst_espera", ST_ESPERA, F_NONE);
        applyStimulus(5'b01111); checkOutput("rst_registra", ST_REGISTRA, F_REG);
        applyStimulus(5'b00111); checkOutput("rst_comparacao", ST_COMPARACAO, F_NONE);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset_mid_comparacao", ST_INICIAL, F_ZERA3);

        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
